eab_agu: RTL and testbench

Parametrised, registered effective-address generation unit for the LC-3 datapath; successor to the combinational effective-address adder. Computes base (PC or register) plus a sign-extended IR offset. Adds a memory-indirect mode (LDI/STI-style pointer fetch) through a request/ready memory port, and delivers the final address through a valid/ready output handshake. Sits between the decode/control FSM and the MAR load path.

---
 rtl/eab_agu.sv | 70 +++++++
 tb/tb_eab_agu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eab_agu.sv
// eab_agu: registered LC-3 effective-address unit with optional memory-indirect pointer fetch.
// Define EAB_AGU_FASTPATH_EN to accept a new request on the same edge the output handshake completes.
module eab_agu #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [10:0]      ir,
   input  logic [WIDTH-1:0] ra,
   input  logic [WIDTH-1:0] pc,
   input  logic             sel_base,
   input  logic [1:0]       sel_off,
   input  logic             indirect,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_rdy,
   input  logic [WIDTH-1:0] mem_data,
   output logic             addr_valid,
   input  logic             addr_ready,
   output logic [WIDTH-1:0] addr_out
);
   typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] off;
   logic [WIDTH-1:0] sum;
   logic accept;
   always_comb begin
      off = sel_off == 2'd1 ? {{(WIDTH-6){ir[5]}}, ir[5:0]} :
            sel_off == 2'd2 ? {{(WIDTH-9){ir[8]}}, ir[8:0]} :
            sel_off == 2'd3 ? {{(WIDTH-11){ir[10]}}, ir[10:0]} : '0;
      sum = (sel_base ? ra : pc) + off;
   end
`ifdef EAB_AGU_FASTPATH_EN
   assign req_ready = state == IDLE || (state == DONE && addr_ready);
`else
   assign req_ready = state == IDLE;
`endif
   assign accept = req_valid && req_ready;
   // accept takes priority: in the fast path it coincides with the DONE handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         addr_valid <= 1'b0;
         addr_out   <= '0;
      end else if (accept) begin
         if (indirect) begin
            state      <= MEM;
            mem_req    <= 1'b1;
            mem_addr   <= sum;
            addr_valid <= 1'b0;
         end else begin
            state      <= DONE;
            addr_out   <= sum;
            addr_valid <= 1'b1;
         end
      end else if (state == MEM && mem_rdy) begin
         state      <= DONE;
         mem_req    <= 1'b0;
         addr_out   <= mem_data;
         addr_valid <= 1'b1;
      end else if (state == DONE && addr_ready) begin
         state      <= IDLE;
         addr_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_eab_agu.sv
// tb_eab_agu: randomized self-checking bench for eab_agu against an arithmetic address model.
module tb_eab_agu;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [10:0] ir = '0;
   logic [15:0] ra = '0;
   logic [15:0] pc = '0;
   logic        sel_base = 1'b0;
   logic [1:0]  sel_off = '0;
   logic        indirect = 1'b0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_rdy = 1'b0;
   logic [15:0] mem_data = '0;
   logic        addr_valid;
   logic        addr_ready = 1'b0;
   logic [15:0] addr_out;
   int errors = 0;
   int checks = 0;

   eab_agu #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .ir(ir), .ra(ra), .pc(pc), .sel_base(sel_base), .sel_off(sel_off),
      .indirect(indirect), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdy(mem_rdy), .mem_data(mem_data), .addr_valid(addr_valid),
      .addr_ready(addr_ready), .addr_out(addr_out)
   );

   always #5 clk = ~clk;

   // Offset taken as a signed integer of the selected field length, added modulo 2^16.
   function automatic logic [15:0] ref_ea(logic [15:0] p, logic [15:0] r, logic [10:0] i,
                                          logic sb, logic [1:0] so);
      int n, v;
      n = so == 0 ? 0 : so == 1 ? 6 : so == 2 ? 9 : 11;
      v = n == 0 ? 0 : int'(i) & ((1 << n) - 1);
      if (n != 0 && v >= (1 << (n - 1))) v -= (1 << n);
      return 16'((sb ? int'(r) : int'(p)) + v);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(logic [15:0] p, logic [15:0] r, logic [10:0] i, logic sb,
                          logic [1:0] so, logic ind);
      pc = p; ra = r; ir = i; sel_base = sb; sel_off = so; indirect = ind;
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 16'h0 || addr_valid !== 1'b0 || addr_out !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b mreq=%b maddr=%h av=%b aout=%h", req_ready, mem_req, mem_addr, addr_valid, addr_out);
      end
      rst = 1'b0;
      tick();
      set_req(16'h1111, 16'h0, 11'h0, 1'b0, 2'd0, 1'b0);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== 16'h1111) begin
         errors++;
         $display("FAIL reset_pre: av=%b aout=%h want 1/1111", addr_valid, addr_out);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1 || mem_req !== 1'b0 || addr_valid !== 1'b0 || addr_out !== 16'h0) begin
         errors++;
         $display("FAIL reset_async: rdy=%b mreq=%b av=%b aout=%h", req_ready, mem_req, addr_valid, addr_out);
      end
      #2 rst = 1'b0;
      tick();
      checks++;
      if (req_ready !== 1'b1 || mem_req !== 1'b0 || addr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b mreq=%b av=%b", req_ready, mem_req, addr_valid);
      end
   endtask

   task automatic test_direct;
      logic [15:0] p[4] = '{16'h3000, 16'h0, 16'h0, 16'h3000};
      logic [15:0] r[4] = '{16'h0, 16'hFFFF, 16'h1234, 16'h0};
      logic [10:0] i[4] = '{11'h1FF, 11'h001, 11'h7FF, 11'h400};
      logic        b[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [1:0]  s[4] = '{2'd2, 2'd1, 2'd0, 2'd3};
      logic [15:0] e[4] = '{16'h2FFF, 16'h0000, 16'h1234, 16'h2C00};
      for (int k = 0; k < 4; k++) begin
         set_req(p[k], r[k], i[k], b[k], s[k], 1'b0);
         req_valid = 1'b1;
         tick();
         req_valid = 1'b0;
         checks++;
         if (addr_valid !== 1'b1 || addr_out !== e[k]) begin
            errors++;
            $display("FAIL direct_%0d: av=%b aout=%h want 1/%h", k, addr_valid, addr_out, e[k]);
         end
         addr_ready = 1'b1;
         tick();
         addr_ready = 1'b0;
      end
   endtask

   task automatic test_indirect;
      set_req(16'h3000, 16'h0, 11'h010, 1'b0, 2'd2, 1'b1);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      set_req(16'($urandom), 16'($urandom), 11'($urandom), 1'b1, 2'd3, 1'b0);
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== 16'h3010 || addr_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL indirect_mem_%0d: mreq=%b maddr=%h av=%b rdy=%b want 1/3010/0/0", c, mem_req, mem_addr, addr_valid, req_ready);
         end
         if (c < 2) tick();
      end
      mem_rdy = 1'b1;
      mem_data = 16'h4000;
      tick();
      mem_data = 16'hBEEF;
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== 16'h4000 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL indirect_done: av=%b aout=%h mreq=%b want 1/4000/0", addr_valid, addr_out, mem_req);
      end
      tick();
      mem_rdy = 1'b0;
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== 16'h4000) begin
         errors++;
         $display("FAIL indirect_rdy_ignored: av=%b aout=%h want 1/4000", addr_valid, addr_out);
      end
      addr_ready = 1'b1;
      tick();
      addr_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      set_req(16'h0, 16'h5000, 11'h020, 1'b1, 2'd1, 1'b0);
      req_valid = 1'b1;
      tick();
      set_req(16'h7777, 16'h7777, 11'h0, 1'b0, 2'd0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (addr_valid !== 1'b1 || addr_out !== 16'h4FE0 || req_ready !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_%0d: av=%b aout=%h rdy=%b mreq=%b want 1/4fe0/0/0", c, addr_valid, addr_out, req_ready, mem_req);
         end
         tick();
      end
      req_valid = 1'b0;
      addr_ready = 1'b1;
      tick();
      addr_ready = 1'b0;
      checks++;
      if (addr_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release: av=%b rdy=%b want 0/1", addr_valid, req_ready);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] bp[4], br[4];
      logic [10:0] bi[4];
      logic [1:0]  bs[4];
      logic        bb[4];
      logic [15:0] q[$];
      logic [15:0] exp;
      int k = 0, done = 0, first = -1, last = -1, want;
      logic acc, hs;
      for (int j = 0; j < 4; j++) begin
         bp[j] = 16'($urandom); br[j] = 16'($urandom); bi[j] = 11'($urandom);
         bs[j] = 2'($urandom); bb[j] = 1'($urandom);
      end
      set_req(bp[0], br[0], bi[0], bb[0], bs[0], 1'b0);
      req_valid = 1'b1;
      addr_ready = 1'b1;
      for (int c = 0; c < 40 && done < 4; c++) begin
         acc = req_valid && req_ready;
         hs = addr_valid && addr_ready;
         if (hs) begin
            exp = q.size() != 0 ? q.pop_front() : 16'hxxxx;
            checks++;
            if (addr_out !== exp) begin
               errors++;
               $display("FAIL b2b_addr_%0d: aout=%h want %h", done, addr_out, exp);
            end
            done++;
            last = c;
         end
         if (acc) begin
            q.push_back(ref_ea(pc, ra, ir, sel_base, sel_off));
            if (first < 0) first = c;
         end
         tick();
         if (acc) begin
            k++;
            if (k < 4) set_req(bp[k], br[k], bi[k], bb[k], bs[k], 1'b0);
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      addr_ready = 1'b0;
`ifdef EAB_AGU_FASTPATH_EN
      want = 4;
`else
      want = 7;
`endif
      checks++;
      if (done !== 4 || last - first !== want) begin
         errors++;
         $display("FAIL b2b_cycles: done=%0d cycles=%0d want 4/%0d", done, last - first, want);
      end
      tick();
   endtask

   task automatic test_random;
      logic [15:0] exp, ptr;
      int lat;
      for (int n = 0; n < 25; n++) begin
         set_req(16'($urandom), 16'($urandom), 11'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
         exp = ref_ea(pc, ra, ir, sel_base, sel_off);
         checks++;
         if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rand_ready_%0d: rdy=%b want 1", n, req_ready);
         end
         req_valid = 1'b1;
         tick();
         req_valid = 1'b0;
         if (indirect) begin
            set_req(16'($urandom), 16'($urandom), 11'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
            lat = $urandom_range(0, 3);
            for (int c = 0; c <= lat; c++) begin
               checks++;
               if (mem_req !== 1'b1 || mem_addr !== exp || addr_valid !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_mem_%0d: mreq=%b maddr=%h av=%b want 1/%h/0", n, mem_req, mem_addr, addr_valid, exp);
               end
               if (c < lat) tick();
            end
            ptr = 16'($urandom);
            mem_rdy = 1'b1;
            mem_data = ptr;
            tick();
            mem_rdy = 1'b0;
            exp = ptr;
         end
         for (int c = $urandom_range(0, 2); c >= 0; c--) begin
            checks++;
            if (addr_valid !== 1'b1 || addr_out !== exp || mem_req !== 1'b0) begin
               errors++;
               $display("FAIL rand_out_%0d: av=%b aout=%h mreq=%b want 1/%h/0", n, addr_valid, addr_out, mem_req, exp);
            end
            if (c > 0) tick();
         end
         addr_ready = 1'b1;
         tick();
         addr_ready = 1'b0;
      end
   endtask

   task automatic test_reset_mid_mem;
      set_req(16'h3000, 16'h0, 11'h005, 1'b0, 2'd1, 1'b1);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h3005) begin
         errors++;
         $display("FAIL rst_mem_pre: mreq=%b maddr=%h want 1/3005", mem_req, mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 16'h0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mem_drop: mreq=%b maddr=%h rdy=%b want 0/0/1", mem_req, mem_addr, req_ready);
      end
      #2 rst = 1'b0;
      mem_rdy = 1'b1;
      mem_data = 16'hABCD;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (addr_valid !== 1'b0 || mem_req !== 1'b0 || addr_out !== 16'h0) begin
            errors++;
            $display("FAIL rst_mem_ignore_%0d: av=%b mreq=%b aout=%h want 0/0/0", c, addr_valid, mem_req, addr_out);
         end
      end
      mem_rdy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_direct();
      test_indirect();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid_mem();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
